id_reg_file_mp: RTL
===================

// Module: id_reg_file_mp
// PURPOSE
//  Parametrised multi-port integer register file for the ID stage: NRD async read ports, NWR sync write ports.
//  Adds write-to-read bypass, a pending-write scoreboard for hazard detection, and a post-reset clear sweep.
//  Sits between decode (read/issue side) and writeback (write side); x0 is hardwired to zero.
// PARAMETERS
//  XLEN    32  data width in bits
//  NREGS   32  architectural registers, power of 2, >=4; AW = $clog2(NREGS)
//  NRD     2   read ports
//  NWR     2   write ports
//  BYPASS  1   1: same-cycle write data forwarded to readers; 0: readers see old value
// PORTS
//  clk        in   1         clock
//  rst        in   1         reset; one clock, reset is synchronous and active-low
//  rd_addr    in   NRD*AW    read addresses, port p at [p*AW +: AW]
//  rd_data    out  NRD*XLEN  read data, port p at [p*XLEN +: XLEN]
//  rd_busy    out  NRD       1 = a write to rd_addr[p] is still pending
//  wr_en      in   NWR       write enables
//  wr_addr    in   NWR*AW    write addresses
//  wr_data    in   NWR*XLEN  write data
//  iss_en     in   1         an instruction issued that will write iss_addr
//  iss_addr   in   AW        destination register of the issued instruction
//  init_done  out  1         1 = clear sweep finished; file is usable
// BEHAVIOUR
//  FSM: INIT, RUN.
//   - rst==0 at posedge: state<=INIT, ptr<=1, busy[]<=0, init_done<=0.
//   - A reset asserted mid-operation has the same effect; in-flight writes are lost.
//  INIT:
//   - Each cycle regs[ptr]<=0 and ptr<=ptr+1.
//   - After ptr==NREGS-1 is cleared: state<=RUN, init_done<=1 on the next cycle.
//   - Sweep length is NREGS-1 cycles after rst deasserts.
//   - During INIT: wr_en and iss_en are ignored; rd_data=0; rd_busy=0.
//  RUN, write:
//   - At posedge, for each w with wr_en[w] && wr_addr[w]!=0: regs[wr_addr[w]]<=wr_data[w].
//   - Several ports to the same address: the highest index w wins.
//  RUN, read (combinational, 0 latency):
//   - rd_addr==0 gives 0.
//   - Else if BYPASS and any wr_en[w] with wr_addr[w]==rd_addr: wr_data of the highest such w.
//   - Else regs[rd_addr].
//  Scoreboard busy[NREGS] (RUN only):
//   - The write clears busy[wr_addr]; iss_en sets busy[iss_addr].
//   - Same-cycle issue and write to the same register: busy ends SET, because the issue is the newer producer.
//   - busy[0] is always 0; iss_addr==0 is ignored.
//   - rd_busy[p] = busy[rd_addr[p]] & ~(BYPASS & same-cycle write hit on rd_addr[p]).
//  Reset values: all regs 0 after the sweep, busy 0, init_done 0.
//   - rd_data and rd_busy are 0 from the first reset edge onward.
// STRUCTURE
//  Shared package/define.h gets these, reused by decode and writeback:
//   - REG_ADDR_W; XLEN default; state encodings ST_INIT=1'b0, ST_RUN=1'b1.
//  One sub-module, id_rf_bypass_mux: per read port, priority-selects wr_data over the regs[] value.
//   - Instantiated NRD times by generate.
//  Storage is a plain flop array (no RAM macro), because reads are asynchronous and there are multiple write ports.
// TESTING
//  1 Reset: hold rst=0 for 2 cycles, release.
//    -> init_done=0 for exactly 31 cycles then 1; every read returns 0; rd_busy=0.
//  2 Write/read: wr_en[0], r5<=0xDEADBEEF.
//    -> same cycle rd_addr=5 gives 0xDEADBEEF (BYPASS=1); next cycle also 0xDEADBEEF; with BYPASS=0 same cycle gives 0.
//  3 x0: write 0x1234 to r0 on both ports, and iss_addr=0.
//    -> read r0=0; rd_busy=0.
//  4 Port conflict: wr0 r7<=0x11 and wr1 r7<=0x22 in the same cycle.
//    -> bypass shows 0x22; r7=0x22 afterward.
//  5 Scoreboard: iss r9 -> rd_busy=1; write r9 -> same-cycle rd_busy=0 and read returns data.
//    -> Issue r9 and write r9 in the same cycle: busy stays 1.
//  6 Reset mid-run: busy r3, r3=0x55, pulse rst=0 for 1 cycle.
//    -> INIT re-entered; r3 reads 0; busy cleared; writes during the sweep are dropped.

Source files
------------

// File: rtl/id_reg_file_mp_pkg.sv
// Shared register-file definitions used by decode, writeback and the ID-stage register file.
package id_reg_file_mp_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int REG_ADDR_W = $clog2(NREGS_DEF);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/id_rf_bypass_mux.sv
// Per-read-port forwarding mux: picks the highest-index same-cycle write hitting the read address
// over the stored register value.
module id_rf_bypass_mux
    import id_reg_file_mp_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int AW     = REG_ADDR_W,
    parameter int NWR    = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic [AW-1:0]       rd_addr_i,
    input  logic [XLEN-1:0]     reg_val_i,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0]     data_o,
    output logic                hit_o
);

    always_comb begin
        data_o = reg_val_i;
        hit_o  = 1'b0;
        // Ascending scan so the highest matching port overrides lower ones.
        for (int w = 0; w < NWR; w++) begin
            if (BYPASS && wr_en_i[w] && (wr_addr_i[w*AW +: AW] == rd_addr_i)) begin
                data_o = wr_data_i[w*XLEN +: XLEN];
                hit_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_reg_file_mp.sv
// ID-stage multi-port register file: async reads with optional write bypass, pending-write
// scoreboard, and a post-reset clear sweep. x0 always reads zero.
module id_reg_file_mp
    import id_reg_file_mp_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                init_done
);

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             init_done_q, init_done_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [XLEN-1:0]  regs_q [NREGS];

    logic             run;
    logic [NWR-1:0]   wr_act;

    // Writes only count in RUN and outside a reset cycle; the same mask drives bypass and scoreboard.
    assign run    = (state_q == ST_RUN);
    assign wr_act = (run && rst) ? wr_en : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            ptr_q       <= AW'(1);
            init_done_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        busy_d      = busy_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == AW'(NREGS - 1)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_act[w]) busy_d[wr_addr[w*AW +: AW]] = 1'b0;
                end
                // Issue applied after writes: the newly issued producer owns the register.
                if (iss_en) busy_d[iss_addr] = 1'b1;
                busy_d[0] = 1'b0;
            end
        endcase
    end

    // Data storage carries no reset; the INIT sweep clears it instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (!run) begin
                regs_q[ptr_q] <= '0;
            end else begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_act[w] && (wr_addr[w*AW +: AW] != '0))
                        regs_q[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] mux_data;
        logic            hit;

        assign ra = rd_addr[p*AW +: AW];

        id_rf_bypass_mux #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWR    (NWR),
            .BYPASS (BYPASS != 0)
        ) u_mux (
            .rd_addr_i (ra),
            .reg_val_i (regs_q[ra]),
            .wr_en_i   (wr_act),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .data_o    (mux_data),
            .hit_o     (hit)
        );

        assign rd_data[p*XLEN +: XLEN] = (run && (ra != '0)) ? mux_data : '0;
        assign rd_busy[p]              = run & busy_q[ra] & ~hit;
    end

    assign init_done = init_done_q;

endmodule
